// File: rtl/note_tone_sequencer_pkg.sv
// Shared types and constants for the note/tone sequencer: FSM state
// encoding, the eight-note scale table and its lookup helper.
package note_tone_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        AUTO_PLAY,
        AUTO_GAP
    } state_t;

    localparam int unsigned NOTE_COUNT = 8;

    // Half-period counts for C5 D5 E5 F5 G5 A5 B5 C6.
    localparam logic [31:0] NOTE_TABLE [NOTE_COUNT] = '{
        32'hBAB9, 32'hA65D, 32'h9430, 32'h8BE9,
        32'h7CB8, 32'h6EF9, 32'h62F1, 32'h5D5D
    };

    function automatic logic [31:0] note_lookup(input logic [2:0] idx);
        return NOTE_TABLE[idx];
    endfunction

endpackage

// File: rtl/note_tone_sequencer.sv
// Note/tone sequencer: selects a note either manually or by stepping
// through the C5..C6 scale with a sound/silence beat, and drives the
// half-period count and audio gate for the downstream clock divider.
module note_tone_sequencer
    import note_tone_sequencer_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 2500000
) (
    input  logic        inclk,
    input  logic        Reset,
    input  logic        play,
    input  logic        mode_auto,
    input  logic [2:0]  sel,
    output logic [31:0] div_clk_count,
    output logic        tone_on,
    output logic [2:0]  note_idx,
    output logic        note_strobe
);

    localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cnt;
    logic [31:0] cnt_nxt;
    logic [2:0]  idx_nxt;
    logic        tone_nxt;

    // Next state, beat counter and note index; !play overrides everything.
    // The counter defaults to zero so any state change clears it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        idx_nxt   = note_idx;
        if (!play) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (mode_auto) begin
                        state_nxt = AUTO_PLAY;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = MANUAL;
                        idx_nxt   = sel;
                    end
                end
                MANUAL: begin
                    if (mode_auto) begin
                        state_nxt = AUTO_PLAY;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = sel;
                    end
                end
                AUTO_PLAY: begin
                    if (!mode_auto) begin
                        state_nxt = MANUAL;
                        idx_nxt   = sel;
                    end else if (cnt == BEAT_LAST) begin
                        state_nxt = AUTO_GAP;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                AUTO_GAP: begin
                    if (!mode_auto) begin
                        state_nxt = MANUAL;
                        idx_nxt   = sel;
                    end else if (cnt == GAP_LAST) begin
                        state_nxt = AUTO_PLAY;
                        idx_nxt   = note_idx + 3'd1;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        tone_nxt = (state_nxt == MANUAL) || (state_nxt == AUTO_PLAY);
    end

    // State and registered outputs; outputs are derived from the next
    // state/index so they become valid in the same cycle as the state.
    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            note_idx      <= '0;
            div_clk_count <= NOTE_TABLE[0];
            tone_on       <= 1'b0;
            note_strobe   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            note_idx <= idx_nxt;
            tone_on  <= tone_nxt;
            if (tone_nxt) begin
                div_clk_count <= note_lookup(idx_nxt);
            end
            note_strobe <= ((state_nxt == AUTO_PLAY) && (state != AUTO_PLAY)) ||
                           ((state_nxt == MANUAL) &&
                            ((state != MANUAL) || (idx_nxt != note_idx)));
        end
    end

endmodule

// File: tb/tb_note_tone_sequencer.sv
// Directed bench for note_tone_sequencer with a scoreboard of expected
// per-cycle outputs (short beat/gap parameters).
module tb_note_tone_sequencer;

    localparam int unsigned BEAT   = 10;
    localparam int unsigned GAP    = 2;
    localparam int unsigned PERIOD = BEAT + GAP;

    localparam logic [31:0] TONES [8] = '{
        32'hBAB9, 32'hA65D, 32'h9430, 32'h8BE9,
        32'h7CB8, 32'h6EF9, 32'h62F1, 32'h5D5D
    };

    typedef struct {
        string       tag;
        logic [2:0]  idx;
        logic        tone;
        logic        strobe;
        logic [31:0] div;
    } exp_t;

    logic        inclk = 1'b0;
    logic        Reset;
    logic        play;
    logic        mode_auto;
    logic [2:0]  sel;
    logic [31:0] div_clk_count;
    logic        tone_on;
    logic [2:0]  note_idx;
    logic        note_strobe;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 inclk = ~inclk;

    note_tone_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP)
    ) dut (
        .inclk        (inclk),
        .Reset        (Reset),
        .play         (play),
        .mode_auto    (mode_auto),
        .sel          (sel),
        .div_clk_count(div_clk_count),
        .tone_on      (tone_on),
        .note_idx     (note_idx),
        .note_strobe  (note_strobe)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] idx, input logic tone,
                        input logic strobe, input logic [31:0] div);
        exp_t e;
        e.tag    = tag;
        e.idx    = idx;
        e.tone   = tone;
        e.strobe = strobe;
        e.div    = div;
        sb.push_back(e);
    endtask

    // Expected outputs k cycles after entry into the auto sequence.
    task automatic push_auto(input string tag, input int unsigned k);
        logic [2:0] idx;
        idx = 3'((k / PERIOD) % 8);
        push(tag, idx, (k % PERIOD) < BEAT, (k % PERIOD) == 0, TONES[idx]);
    endtask

    task automatic step();
        @(posedge inclk);
        #1;
    endtask

    task automatic step_check();
        exp_t e;
        step();
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: observed empty queue, required an entry");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, "_idx"},    32'(note_idx),    32'(e.idx));
            cmp({e.tag, "_tone"},   32'(tone_on),     32'(e.tone));
            cmp({e.tag, "_strobe"}, 32'(note_strobe), 32'(e.strobe));
            cmp({e.tag, "_div"},    div_clk_count,    e.div);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset     = 1'b0;
        play      = 1'b0;
        mode_auto = 1'b0;
        sel       = 3'd0;
        #12;
        cmp("rst_tone",   32'(tone_on),     32'd0);
        cmp("rst_idx",    32'(note_idx),    32'd0);
        cmp("rst_strobe", 32'(note_strobe), 32'd0);
        cmp("rst_div",    div_clk_count,    32'hBAB9);
        @(posedge inclk);
        #3;
        Reset = 1'b1;

        // Idle with play low
        repeat (5) begin
            step();
            cmp("idle_tone",   32'(tone_on),     32'd0);
            cmp("idle_strobe", 32'(note_strobe), 32'd0);
            cmp("idle_div",    div_clk_count,    32'hBAB9);
        end

        // Manual mode
        sel  = 3'd5;
        play = 1'b1;
        push("man_enter", 3'd5, 1'b1, 1'b1, 32'h6EF9);
        step_check();
        repeat (4) begin
            push("man_hold", 3'd5, 1'b1, 1'b0, 32'h6EF9);
            step_check();
        end
        sel = 3'd2;
        push("man_sel", 3'd2, 1'b1, 1'b1, 32'h9430);
        step_check();
        push("man_sel_hold", 3'd2, 1'b1, 1'b0, 32'h9430);
        step_check();

        // Auto mode with sel churning; runs past the 7->0 wrap
        mode_auto = 1'b1;
        for (int unsigned k = 0; k < 125; k++) begin
            sel = 3'($urandom_range(0, 7));
            push_auto("auto", k);
            step_check();
        end

        // Drop play mid-note (idx 2), then restart
        play = 1'b0;
        step();
        cmp("drop_tone",   32'(tone_on),     32'd0);
        cmp("drop_strobe", 32'(note_strobe), 32'd0);
        cmp("drop_div",    div_clk_count,    32'h9430);
        step();
        cmp("drop_tone2",  32'(tone_on),     32'd0);
        play = 1'b1;
        for (int unsigned k = 0; k < 42; k++) begin
            push_auto("restart", k);
            step_check();
        end

        // Asynchronous reset mid-note at idx 3
        #2;
        Reset = 1'b0;
        #1;
        cmp("areset_tone",   32'(tone_on),     32'd0);
        cmp("areset_idx",    32'(note_idx),    32'd0);
        cmp("areset_strobe", 32'(note_strobe), 32'd0);
        cmp("areset_div",    div_clk_count,    32'hBAB9);
        @(posedge inclk);
        #3;
        cmp("areset_hold_tone", 32'(tone_on), 32'd0);
        Reset = 1'b1;
        for (int unsigned k = 0; k < 13; k++) begin
            push_auto("post_rst", k);
            step_check();
        end

        // Auto -> manual from play and from gap
        mode_auto = 1'b0;
        sel       = 3'd6;
        push("play_to_man", 3'd6, 1'b1, 1'b1, 32'h62F1);
        step_check();
        mode_auto = 1'b1;
        for (int unsigned k = 0; k < 11; k++) begin
            push_auto("auto2", k);
            step_check();
        end
        mode_auto = 1'b0;
        sel       = 3'd3;
        push("gap_to_man", 3'd3, 1'b1, 1'b1, 32'h8BE9);
        step_check();
        push("man_hold2", 3'd3, 1'b1, 1'b0, 32'h8BE9);
        step_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
